// File: rtl/add_sub_serial.sv
// ---------------------------------------------------------------------------
// add_sub_serial
// Digit-serial adder/subtractor with valid/ready handshakes on both sides.
// One operand pair is accepted in IDLE, DIGIT bits are summed per clock over
// WIDTH/DIGIT steps in BUSY, and the result is held in DONE until the
// consumer takes it. Subtraction is A + ~B + 1 (carry-in seeded with sub).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (decode of IDLE)
//   a, b       WIDTH-bit operands
//   sub        0: A+B, 1: A-B
//   out_valid  result valid (registered)
//   out_ready  consumer accepts result
//   sum        WIDTH-bit result modulo 2^WIDTH (registered)
//   cout       carry out of MSB; on subtract 1 means no borrow
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   zero       sum == 0
// ---------------------------------------------------------------------------
module add_sub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("add_sub_serial: WIDTH must be at least 2");
        end
        if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
            $error("add_sub_serial: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;      // already inverted for subtract
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [WIDTH-1:0]   acc_q, acc_d;  // working sum filled digit by digit
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               out_valid_q, out_valid_d;

    int                 idx_s;
    logic [DIGIT-1:0]   a_dig_s;
    logic [DIGIT-1:0]   b_dig_s;
    logic [DIGIT:0]     dsum_s;
    logic               cin_msb_s;
    logic [WIDTH-1:0]   acc_step_s;

    assign idx_s   = int'(k_q) * DIGIT;
    assign a_dig_s = a_q[idx_s +: DIGIT];
    assign b_dig_s = b_q[idx_s +: DIGIT];
    assign dsum_s  = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of the digit, recovered from that bit's sum;
    // only meaningful on the final (MSB) digit step.
    assign cin_msb_s = dsum_s[DIGIT-1] ^ a_dig_s[DIGIT-1] ^ b_dig_s[DIGIT-1];

    // Working sum with the current digit result merged in.
    always_comb begin
        acc_step_s = acc_q;
        acc_step_s[idx_s +: DIGIT] = dsum_s[DIGIT-1:0];
    end

    // Next-state and datapath control for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        k_d         = k_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                acc_d   = acc_step_s;
                carry_d = dsum_s[DIGIT];
                if (k_q == LAST_K) begin
                    k_d         = '0;
                    sum_d       = acc_step_s;
                    cout_d      = dsum_s[DIGIT];
                    ovf_d       = cin_msb_s ^ dsum_s[DIGIT];
                    zero_d      = (acc_step_s == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, operand, working and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
